// File: rtl/wb_master_bridge_pkg.sv
// Shared Wishbone definitions: request size codes, bridge FSM states,
// bus widths and the alignment rule used when a request is accepted.
package wb_master_bridge_pkg;

    localparam int ADR_W  = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } wb_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_RESP = 2'b10
    } bridge_state_e;

    // A request never reaches the bus if its size is illegal or its
    // address is not a multiple of the access size.
    function automatic logic is_misaligned(input wb_size_e size, input logic [1:0] adr_lo);
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = adr_lo[0];
            SZ_WORD: bad = |adr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane alignment between the core's right-aligned data and the
// 32-bit Wishbone data bus. The store side works on the incoming request so
// its results can be registered at acceptance; the load side works on the
// latched request and the slave's read data.
module wb_lane_align
    import wb_master_bridge_pkg::*;
(
    input  wb_size_e          wr_size,
    input  logic [1:0]        wr_adr,
    input  logic [DATA_W-1:0] wr_dat,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_rep,
    input  wb_size_e          rd_size,
    input  logic [1:0]        rd_adr,
    input  logic              rd_unsigned,
    input  logic [DATA_W-1:0] rd_raw,
    output logic [DATA_W-1:0] rd_ext
);

    logic signed [7:0]  rd_byte;
    logic signed [15:0] rd_half;

    // Lane select and write-data replication across all lanes the access may hit
    always_comb begin
        wr_sel = '0;
        wr_rep = '0;
        case (wr_size)
            SZ_BYTE: begin
                wr_sel = 4'b0001 << wr_adr;
                wr_rep = {4{wr_dat[7:0]}};
            end
            SZ_HALF: begin
                wr_sel = 4'b0011 << wr_adr;
                wr_rep = {2{wr_dat[15:0]}};
            end
            SZ_WORD: begin
                wr_sel = 4'b1111;
                wr_rep = wr_dat;
            end
            default: ;
        endcase
    end

    // Pick the addressed lane of the read data and extend it to 32 bits
    always_comb begin
        rd_byte = signed'(rd_raw[{rd_adr, 3'b000} +: 8]);
        rd_half = signed'(rd_raw[{rd_adr[1], 4'b0000} +: 16]);
        rd_ext  = '0;
        case (rd_size)
            SZ_BYTE: rd_ext = rd_unsigned ? {24'b0, rd_byte} : 32'(rd_byte);
            SZ_HALF: rd_ext = rd_unsigned ? {16'b0, rd_half} : 32'(rd_half);
            SZ_WORD: rd_ext = rd_raw;
            default: rd_ext = '0;
        endcase
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Core load/store request to single Wishbone classic cycle bridge.
// One transfer at a time: IDLE accepts, BUS runs the cycle with a timeout,
// RESP emits a one-cycle response and returns to IDLE.
module wb_master_bridge
    import wb_master_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_vld,
    output logic              o_req_rdy,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADR_W-1:0]  i_req_adr,
    input  logic [DATA_W-1:0] i_req_dat,
    output logic              o_rsp_vld,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_rsp_dat,
    output logic              o_wbm_cyc,
    output logic              o_wbm_stb,
    output logic              o_wbm_we,
    output logic [SEL_W-1:0]  o_wbm_sel,
    output logic [ADR_W-1:0]  o_wbm_adr,
    output logic [DATA_W-1:0] o_wbm_dat,
    input  logic              i_wbs_ack,
    input  logic [DATA_W-1:0] i_wbs_dat
);

    // The counter value seen in the last allowed BUS cycle; the timeout
    // fires on the edge that ends that cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    bridge_state_e     state;
    bridge_state_e     state_nxt;
    wb_size_e          req_size;
    wb_size_e          size_q;
    logic              unsigned_q;
    logic              we_q;
    logic              cyc;
    logic              accept;
    logic              bus_ack;
    logic              bus_timeout;
    logic              misalign;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  sel_in;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] rep_in;
    logic [DATA_W-1:0] wdat_q;
    logic [ADR_W-1:0]  adr_q;
    logic [DATA_W-1:0] rd_ext;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_dat;

    assign req_size = wb_size_e'(i_req_size);
    assign misalign = is_misaligned(req_size, i_req_adr[1:0]);

    wb_lane_align u_lane (
        .wr_size    (req_size),
        .wr_adr     (i_req_adr[1:0]),
        .wr_dat     (i_req_dat),
        .wr_sel     (sel_in),
        .wr_rep     (rep_in),
        .rd_size    (size_q),
        .rd_adr     (adr_q[1:0]),
        .rd_unsigned(unsigned_q),
        .rd_raw     (i_wbs_dat),
        .rd_ext     (rd_ext)
    );

    assign o_req_rdy = (state == ST_IDLE);
    assign o_rsp_vld = (state == ST_RESP);
    assign o_rsp_err = rsp_err;
    assign o_rsp_dat = rsp_dat;
    assign o_wbm_cyc = cyc;
    assign o_wbm_stb = cyc;
    assign o_wbm_we  = we_q;
    assign o_wbm_sel = sel_q;
    assign o_wbm_adr = adr_q;
    assign o_wbm_dat = wdat_q;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; ack has priority over a coincident timeout
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        bus_ack     = 1'b0;
        bus_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req_vld) begin
                    accept    = 1'b1;
                    state_nxt = misalign ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (i_wbs_ack) begin
                    bus_ack   = 1'b1;
                    state_nxt = ST_RESP;
                end else if (cnt == CNT_LAST) begin
                    bus_timeout = 1'b1;
                    state_nxt   = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, bus outputs, wait counter and response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cyc        <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            size_q     <= SZ_BYTE;
            unsigned_q <= 1'b0;
            cnt        <= '0;
            rsp_err    <= 1'b0;
            rsp_dat    <= '0;
        end else begin
            if (accept) begin
                we_q       <= i_req_we;
                sel_q      <= sel_in;
                adr_q      <= i_req_adr;
                wdat_q     <= rep_in;
                size_q     <= req_size;
                unsigned_q <= i_req_unsigned;
                cnt        <= '0;
                cyc        <= ~misalign;
                rsp_err    <= misalign;
                rsp_dat    <= '0;
            end
            if (state == ST_BUS) begin
                cnt <= cnt + 1'b1;
            end
            if (bus_ack) begin
                cyc     <= 1'b0;
                rsp_err <= 1'b0;
                rsp_dat <= we_q ? '0 : rd_ext;
            end
            if (bus_timeout) begin
                cyc     <= 1'b0;
                rsp_err <= 1'b1;
                rsp_dat <= '0;
            end
            if (state == ST_RESP) begin
                rsp_err <= 1'b0;
                rsp_dat <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: directed scenarios plus randomized transfers
// compared against an arithmetic reference of the bridge's behaviour.
module tb_wb_master_bridge;

    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_vld;
    logic        req_rdy;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_adr;
    logic [31:0] req_dat;
    logic        rsp_vld;
    logic        rsp_err;
    logic [31:0] rsp_dat;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [3:0]  wbm_sel;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat;
    logic        wbs_ack;
    logic [31:0] wbs_dat;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_no = 0;

    wb_master_bridge #(.TIMEOUT_CYC(TO)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_vld     (req_vld),
        .o_req_rdy     (req_rdy),
        .i_req_we      (req_we),
        .i_req_size    (req_size),
        .i_req_unsigned(req_unsigned),
        .i_req_adr     (req_adr),
        .i_req_dat     (req_dat),
        .o_rsp_vld     (rsp_vld),
        .o_rsp_err     (rsp_err),
        .o_rsp_dat     (rsp_dat),
        .o_wbm_cyc     (wbm_cyc),
        .o_wbm_stb     (wbm_stb),
        .o_wbm_we      (wbm_we),
        .o_wbm_sel     (wbm_sel),
        .o_wbm_adr     (wbm_adr),
        .o_wbm_dat     (wbm_dat),
        .i_wbs_ack     (wbs_ack),
        .i_wbs_dat     (wbs_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Load result from the rules: pick the addressed lane, then extend.
    function automatic logic [31:0] ref_load(input logic [1:0] sz, input int lo,
                                             input logic uns, input logic [31:0] sdat);
        longint v;
        case (sz)
            2'd0: begin
                v = longint'((sdat >> (8 * lo)) & 32'hFF);
                if (!uns && v >= 128) v = v - 256;
            end
            2'd1: begin
                v = longint'((sdat >> (8 * lo)) & 32'hFFFF);
                if (!uns && v >= 32768) v = v - 65536;
            end
            default: v = longint'(sdat);
        endcase
        return v[31:0];
    endfunction

    // One request with a slave that acks after 'waits' wait states.
    // Entered and left at posedge+1 with the bridge idle.
    task automatic do_txn(input string tag, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] adr, input logic [31:0] d,
                          input int waits, input logic [31:0] sdat,
                          output int acc_at, output logic [3:0] o_sel,
                          output logic [31:0] o_wdat, output logic o_err,
                          output logic [31:0] o_dat, output int o_cyc);
        int lo, exp_cyc, rsp_cnt, rsp_at, nb;
        logic mis, tmo, exp_err, done, bus_bad;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdat, exp_dat;

        lo  = int'(adr[1:0]);
        mis = (sz == 2'd3) || (sz == 2'd1 && lo % 2 == 1) || (sz == 2'd2 && lo != 0);
        tmo = !mis && (waits + 1 > TO);
        exp_cyc = mis ? 0 : (tmo ? TO : waits + 1);
        exp_err = mis || tmo;
        exp_dat = (exp_err || we) ? 32'h0 : ref_load(sz, lo, uns, sdat);
        case (sz)
            2'd0: begin exp_sel = 4'(1 << lo); exp_wdat = 32'(d[7:0])  * 32'h0101_0101; end
            2'd1: begin exp_sel = 4'(3 << lo); exp_wdat = 32'(d[15:0]) * 32'h0001_0001; end
            default: begin exp_sel = 4'hF; exp_wdat = d; end
        endcase

        req_vld = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_adr = adr; req_dat = d;
        check({tag, ".rdy"}, 32'(req_rdy), 32'd1);
        @(posedge clk); #1;
        acc_at = cyc_no;
        // Scramble the request inputs: the bridge must use its latched copy.
        req_vld = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_adr = $urandom; req_dat = $urandom;

        rsp_cnt = 0; rsp_at = -1; nb = 0; done = 1'b0; bus_bad = 1'b0;
        o_sel = 4'h0; o_wdat = 32'h0; o_err = 1'b0; o_dat = 32'h0;
        for (int c = 0; c < 30; c++) begin
            if (wbm_stb !== wbm_cyc) bus_bad = 1'b1;
            if (rsp_vld) begin
                if (rsp_cnt == 0) begin
                    rsp_at = c; o_err = rsp_err; o_dat = rsp_dat;
                end
                rsp_cnt++;
            end
            if (rsp_cnt > 0 && req_rdy) begin
                done = 1'b1;
                break;
            end
            if (wbm_cyc) begin
                nb++;
                if (nb == 1) begin o_sel = wbm_sel; o_wdat = wbm_dat; end
                if (wbm_adr !== adr || wbm_we !== we || wbm_sel !== exp_sel) bus_bad = 1'b1;
                if (we && wbm_dat !== exp_wdat) bus_bad = 1'b1;
                wbs_ack = (nb == waits + 1);
                wbs_dat = wbs_ack ? sdat : $urandom;
            end else begin
                // Outside a bus cycle the ack must be ignored.
                wbs_ack = 1'($urandom);
                wbs_dat = $urandom;
            end
            @(posedge clk); #1;
        end
        wbs_ack = 1'b0;
        o_cyc = nb;

        check({tag, ".done"},   32'(done),    32'd1);
        check({tag, ".rspcnt"}, 32'(rsp_cnt), 32'd1);
        check({tag, ".err"},    32'(o_err),   32'(exp_err));
        check({tag, ".dat"},    o_dat,        exp_dat);
        check({tag, ".cyc"},    32'(nb),      32'(exp_cyc));
        check({tag, ".lat"},    32'(rsp_at),  32'(exp_cyc));
        check({tag, ".bus"},    32'(bus_bad), 32'd0);
        if (!mis) check({tag, ".sel"}, 32'(o_sel), 32'(exp_sel));
    endtask

    initial begin
        int a0, a1, cy, rsp_seen;
        logic [3:0]  sel;
        logic [31:0] wd, dt;
        logic        er;

        rst_n = 1'b0; req_vld = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_adr = 32'h0; req_dat = 32'h0;
        wbs_ack = 1'b0; wbs_dat = 32'h0;

        #12;
        check("rst.rdy",     32'(req_rdy), 32'd1);
        check("rst.rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst.rsp_err", 32'(rsp_err), 32'd0);
        check("rst.rsp_dat", rsp_dat,      32'd0);
        check("rst.cyc",     32'(wbm_cyc), 32'd0);
        check("rst.stb",     32'(wbm_stb), 32'd0);
        check("rst.we",      32'(wbm_we),  32'd0);
        check("rst.sel",     32'(wbm_sel), 32'd0);
        check("rst.adr",     wbm_adr,      32'd0);
        check("rst.wdat",    wbm_dat,      32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Byte store, one wait state
        do_txn("bst", 1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1, 32'h1234_5678,
               a0, sel, wd, er, dt, cy);
        check("bst.sel_k",  32'(sel), 32'h8);
        check("bst.wdat_k", wd,       32'hA5A5_A5A5);
        check("bst.cyc_k",  32'(cy),  32'd2);

        // Signed and unsigned half loads
        do_txn("hls", 1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h8001_0000,
               a0, sel, wd, er, dt, cy);
        check("hls.sel_k", 32'(sel), 32'hC);
        check("hls.dat_k", dt,       32'hFFFF_8001);
        do_txn("hlu", 1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 2, 32'h8001_0000,
               a0, sel, wd, er, dt, cy);
        check("hlu.dat_k", dt, 32'h0000_8001);

        // Misaligned word load
        do_txn("mis", 1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 0, 32'hDEAD_BEEF,
               a0, sel, wd, er, dt, cy);
        check("mis.err_k", 32'(er), 32'd1);
        check("mis.cyc_k", 32'(cy), 32'd0);

        // Slave never acks
        do_txn("tmo", 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0, 100, 32'hCAFE_F00D,
               a0, sel, wd, er, dt, cy);
        check("tmo.cyc_k", 32'(cy), 32'(TO));
        check("tmo.err_k", 32'(er), 32'd1);
        check("tmo.dat_k", dt,      32'd0);

        // Ack on the same edge as the timeout
        do_txn("race", 1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, TO - 1, 32'h0BAD_CAFE,
               a0, sel, wd, er, dt, cy);
        check("race.err_k", 32'(er), 32'd0);
        check("race.dat_k", dt,      32'h0BAD_CAFE);

        // Back-to-back zero-wait word stores
        do_txn("b2b0", 1'b1, 2'd2, 1'b0, 32'h0000_1000, 32'h1111_2222, 0, 32'h0,
               a0, sel, wd, er, dt, cy);
        do_txn("b2b1", 1'b1, 2'd2, 1'b0, 32'h0000_1004, 32'h3333_4444, 0, 32'h0,
               a1, sel, wd, er, dt, cy);
        check("b2b.spacing", 32'(a1 - a0), 32'd3);

        // Randomized transfers
        for (int i = 0; i < 40; i++) begin
            do_txn($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                   $urandom, $urandom, int'($urandom_range(0, 5)), $urandom,
                   a0, sel, wd, er, dt, cy);
        end

        // Reset during a bus cycle
        req_vld = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_adr = 32'h0000_0200; req_dat = 32'h0; wbs_ack = 1'b0;
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(posedge clk); #1;
        check("rbus.cyc_before", 32'(wbm_cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rbus.cyc_async", 32'(wbm_cyc), 32'd0);
        check("rbus.stb_async", 32'(wbm_stb), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (rsp_vld) rsp_seen++;
        end
        check("rbus.no_rsp", 32'(rsp_seen), 32'd0);
        check("rbus.rdy",    32'(req_rdy),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
